// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - symbol codes and segment constants shared by the lock ASM and display driver
package ssd_pkg;

  localparam logic [4:0] CODE_C     = 5'b01010;
  localparam logic [4:0] CODE_L     = 5'b01011;
  localparam logic [4:0] CODE_S     = 5'b01100;
  localparam logic [4:0] CODE_D     = 5'b01101;
  localparam logic [4:0] CODE_O     = 5'b01110;
  localparam logic [4:0] CODE_P     = 5'b01111;
  localparam logic [4:0] CODE_E     = 5'b10000;
  localparam logic [4:0] CODE_N     = 5'b10001;
  localparam logic [4:0] CODE_DASH  = 5'b10010;
  localparam logic [4:0] CODE_BLANK = 5'b10011;
  localparam logic [4:0] CODE_R     = 5'b10100;

  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
  localparam logic [19:0] BLANK_WORD = {CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_BLANK};

endpackage

// File: rtl/ssd_code_decoder.sv
// rtl/ssd_code_decoder.sv - 5-bit symbol code to active-low {g,f,e,d,c,b,a} pattern
module ssd_code_decoder
  import ssd_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'd0:       seg = 7'b1000000;
      5'd1:       seg = 7'b1111001;
      5'd2:       seg = 7'b0100100;
      5'd3:       seg = 7'b0110000;
      5'd4:       seg = 7'b0011001;
      5'd5:       seg = 7'b0010010;
      5'd6:       seg = 7'b0000010;
      5'd7:       seg = 7'b1111000;
      5'd8:       seg = 7'b0000000;
      5'd9:       seg = 7'b0010000;
      CODE_C:     seg = 7'b1000110;
      CODE_L:     seg = 7'b1000111;
      CODE_S:     seg = 7'b0010010;
      CODE_D:     seg = 7'b0100001;
      CODE_O:     seg = 7'b1000000;
      CODE_P:     seg = 7'b0001100;
      CODE_E:     seg = 7'b0000110;
      CODE_N:     seg = 7'b0101011;
      CODE_DASH:  seg = 7'b0111111;
      CODE_BLANK: seg = SEG_BLANK;
      CODE_R:     seg = 7'b0101111;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - 4-digit common-anode scan driver with per-frame latching and per-digit blink
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [19:0] ssd_in,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  AN,
  output logic [6:0]  seven_out,
  output logic        frame_done
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [1:0]         idx;
  logic [19:0]        shadow;
  logic [3:0]         mask_shadow;

  logic [4:0] cur_code;
  logic [6:0] cur_seg;
  logic       cur_blank;
  logic [3:0] an_next;
  logic [6:0] seg_next;

  // Inputs are sampled only at the start of a frame so a digit never mixes two code words.
  wire capture = (scan_cnt == '0) && (idx == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt    <= '0;
      idx         <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      shadow      <= BLANK_WORD;
      mask_shadow <= 4'b0000;
      frame_done  <= 1'b0;
      AN          <= 4'b1111;
      seven_out   <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      frame_done <= capture;
      if (capture) begin
        shadow      <= ssd_in;
        mask_shadow <= blink_mask;
      end

      AN        <= an_next;
      seven_out <= seg_next;
    end
  end

  always_comb begin
    cur_code = shadow[19:15];
    case (idx)
      2'd0: cur_code = shadow[19:15];
      2'd1: cur_code = shadow[14:10];
      2'd2: cur_code = shadow[9:5];
      2'd3: cur_code = shadow[4:0];
      default: cur_code = shadow[19:15];
    endcase
  end

  ssd_code_decoder u_decoder (
    .code (cur_code),
    .seg  (cur_seg)
  );

  // idx k drives AN[3-k]; the blink bit is looked up by anode position.
  always_comb begin
    cur_blank = blink_phase & mask_shadow[2'd3 - idx];
    an_next   = 4'b1111;
    seg_next  = SEG_BLANK;
    if (en) begin
      an_next  = ~(4'b1000 >> idx);
      seg_next = cur_blank ? SEG_BLANK : cur_seg;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - directed self-checking bench for ssd_scan_driver
module tb_ssd_scan_driver;
  import ssd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [19:0] ssd_in = BLANK_WORD;
  logic [3:0]  blink_mask = 4'b0000;
  logic [3:0]  AN;
  logic [6:0]  seven_out;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  ssd_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ssd_in     (ssd_in),
    .blink_mask (blink_mask),
    .AN         (AN),
    .seven_out  (seven_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst low; the next tick is edge E1 after release (first capture).
  task automatic do_reset(input logic [19:0] word, input logic [3:0] mask);
    rst = 1'b1;
    ssd_in = word;
    blink_mask = mask;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (AN !== 4'b1111) begin n_fail++; $display("FAIL reset_an got=%b exp=1111", AN); end
    n_checks++;
    if (seven_out !== SEG_BLANK) begin n_fail++; $display("FAIL reset_seg got=%b exp=%b", seven_out, SEG_BLANK); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    exp_an  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    exp_seg = '{7'b1000110, 7'b1000111, 7'b0010010, 7'b0100001};
    en = 1'b1;
    do_reset({CODE_C, CODE_L, CODE_S, CODE_D}, 4'b0000);
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 1) begin
        n_checks++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL scan_first_capture got=%b exp=1", frame_done); end
      end
      if (n == 2) begin
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL scan_pulse_width got=%b exp=0", frame_done); end
      end
      if ((n % 4) == 2) begin
        n_checks++;
        if (AN !== exp_an[n/4] || seven_out !== exp_seg[n/4]) begin
          n_fail++;
          $display("FAIL scan_digit%0d got=%b/%b exp=%b/%b", n/4, AN, seven_out, exp_an[n/4], exp_seg[n/4]);
        end
      end
    end
  endtask

  task automatic test_midframe();
    logic [6:0] exp_seg [8];
    int pulses;
    exp_seg = '{7'b1000000, 7'b0001100, 7'b0000110, 7'b0101011, SEG_1, SEG_2, SEG_3, SEG_4};
    pulses = 0;
    en = 1'b1;
    do_reset({CODE_O, CODE_P, CODE_E, CODE_N}, 4'b0000);
    for (int n = 1; n <= 32; n++) begin
      tick();
      if (frame_done === 1'b1) pulses++;
      if (n == 4) ssd_in = {5'd1, 5'd2, 5'd3, 5'd4};
      if ((n % 4) == 2 && n >= 6) begin
        n_checks++;
        if (seven_out !== exp_seg[n/4]) begin
          n_fail++;
          $display("FAIL midframe_e%0d got=%b exp=%b", n, seven_out, exp_seg[n/4]);
        end
      end
    end
    n_checks++;
    if (pulses != 2) begin n_fail++; $display("FAIL midframe_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_blink();
    int k;
    int bad;
    logic [3:0] ea;
    logic [6:0] es;
    bad = 0;
    en = 1'b1;
    do_reset({5'd0, CODE_DASH, CODE_DASH, CODE_DASH}, 4'b1000);
    for (int n = 1; n <= 96; n++) begin
      tick();
      if (n >= 2) begin
        k  = ((n - 1) / 4) % 4;
        ea = ~(4'b1000 >> k);
        if (k == 0) es = ((((n - 1) / 32) % 2) == 1) ? SEG_BLANK : SEG_0;
        else        es = SEG_DASH;
        n_checks++;
        if (AN !== ea || seven_out !== es) begin
          n_fail++;
          bad++;
          if (bad < 5) $display("FAIL blink_e%0d got=%b/%b exp=%b/%b", n, AN, seven_out, ea, es);
        end
      end
    end
  endtask

  task automatic test_enable();
    en = 1'b1;
    do_reset({5'd1, 5'd2, 5'd3, 5'd4}, 4'b0000);
    for (int n = 1; n <= 5; n++) tick();
    en = 1'b0;
    for (int n = 6; n <= 15; n++) begin
      tick();
      n_checks++;
      if (AN !== 4'b1111 || seven_out !== SEG_BLANK) begin
        n_fail++;
        $display("FAIL enable_off_e%0d got=%b/%b exp=1111/%b", n, AN, seven_out, SEG_BLANK);
      end
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (AN !== 4'b1110 || seven_out !== SEG_4) begin
      n_fail++;
      $display("FAIL enable_resume got=%b/%b exp=1110/%b", AN, seven_out, SEG_4);
    end
  endtask

  task automatic test_codes();
    logic [19:0] words [3];
    logic [6:0]  exp_seg [12];
    words   = '{{5'b10101, 5'b11111, 5'b10100, 5'b10011},
                {5'd5, 5'd6, 5'd7, 5'd8},
                {5'd9, CODE_E, CODE_DASH, CODE_BLANK}};
    exp_seg = '{SEG_BLANK, SEG_BLANK, 7'b0101111, SEG_BLANK,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
                7'b0010000, 7'b0000110, SEG_DASH, SEG_BLANK};
    en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      do_reset(words[w], 4'b0000);
      for (int n = 1; n <= 14; n++) begin
        tick();
        if ((n % 4) == 2) begin
          n_checks++;
          if (seven_out !== exp_seg[w*4 + n/4]) begin
            n_fail++;
            $display("FAIL codes_w%0d_d%0d got=%b exp=%b", w, n/4, seven_out, exp_seg[w*4 + n/4]);
          end
        end
      end
    end
  endtask

  task automatic test_midframe_reset();
    en = 1'b1;
    do_reset({5'd1, 5'd2, 5'd3, 5'd4}, 4'b0000);
    for (int n = 1; n <= 10; n++) tick();
    n_checks++;
    if (AN !== 4'b1101 || seven_out !== SEG_3) begin
      n_fail++;
      $display("FAIL rst_pre got=%b/%b exp=1101/%b", AN, seven_out, SEG_3);
    end
    rst = 1'b1;
    ssd_in = {5'd5, 5'd6, 5'd7, 5'd8};
    tick();
    n_checks++;
    if (AN !== 4'b1111 || seven_out !== SEG_BLANK || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_blank got=%b/%b/%b exp=1111/%b/0", AN, seven_out, frame_done, SEG_BLANK);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (frame_done !== 1'b1) begin n_fail++; $display("FAIL rst_recapture got=%b exp=1", frame_done); end
    tick();
    n_checks++;
    if (AN !== 4'b0111 || seven_out !== 7'b0010010) begin
      n_fail++;
      $display("FAIL rst_first_digit got=%b/%b exp=0111/0010010", AN, seven_out);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe();
    test_blink();
    test_enable();
    test_codes();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
